entity_table: RTL and testbench

ENTITY_TABLE -- requirements
Module: entity_table

---
 rtl/entity_pkg.sv | 29 ++
 rtl/entity_scanner.sv | 119 +++++++++++
 rtl/entity_table.sv | 97 +++++++++
 tb/tb_entity_table.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entity_pkg.sv
// entity_pkg: shared entity slot record, scanner state encoding and player reset constants.
// Rev 1.0
`default_nettype none

package entity_pkg;

    localparam int ENT_ID_W    = 4;
    localparam int ENT_COORD_W = 9;

    localparam logic [ENT_ID_W-1:0]    PLAYER_ID = '0;
    localparam logic [ENT_COORD_W-1:0] PLAYER_X  = ENT_COORD_W'(32);
    localparam logic [ENT_COORD_W-1:0] PLAYER_Y  = ENT_COORD_W'(32);

    typedef struct packed {
        logic [ENT_ID_W-1:0]    id;
        logic [ENT_COORD_W-1:0] x;
        logic [ENT_COORD_W-1:0] y;
        logic                   valid;
    } entity_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/entity_scanner.sv
// entity_scanner: walks the slot table once per frame and streams valid slots over a valid/ready port.
// Rev 1.0
`default_nettype none

module entity_scanner
    import entity_pkg::*;
#(
    parameter int NUM_ENTITIES = 16,
    localparam int AW = $clog2(NUM_ENTITIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   out_ready,
    input  entity_t                slot,
    output logic [AW-1:0]          scan_index,
    output logic                   out_valid,
    output logic [ENT_ID_W-1:0]    out_id,
    output logic [ENT_COORD_W-1:0] out_x,
    output logic [ENT_COORD_W-1:0] out_y,
    output logic [AW-1:0]          out_index,
    output logic                   scan_busy,
    output logic                   scan_done
);

    localparam logic [AW-1:0] C_LAST = AW'(NUM_ENTITIES - 1);

    scan_state_t            r_state, w_state;
    logic [AW-1:0]          r_idx, w_idx;
    logic                   r_valid, w_valid;
    logic [ENT_ID_W-1:0]    r_id, w_id;
    logic [ENT_COORD_W-1:0] r_x, w_x, r_y, w_y;
    logic [AW-1:0]          r_oidx, w_oidx;
    logic                   r_done, w_done;
    logic                   w_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_oidx  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_valid <= w_valid;
            r_id    <= w_id;
            r_x     <= w_x;
            r_y     <= w_y;
            r_oidx  <= w_oidx;
            r_done  <= w_done;
        end
    end

    // The output register may advance when it is empty or its beat is being taken this cycle.
    assign w_free = !r_valid || out_ready;

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_valid = r_valid;
        w_id    = r_id;
        w_x     = r_x;
        w_y     = r_y;
        w_oidx  = r_oidx;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_state = ST_SCAN;
                    w_idx   = '0;
                end
            end
            ST_SCAN: begin
                if (w_free) begin
                    w_valid = slot.valid;
                    if (slot.valid) begin
                        w_id   = slot.id;
                        w_x    = slot.x;
                        w_y    = slot.y;
                        w_oidx = r_idx;
                    end
                    if (r_idx == C_LAST) begin
                        w_state = ST_DRAIN;
                    end else begin
                        w_idx = r_idx + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (w_free) begin
                    w_valid = 1'b0;
                    w_done  = 1'b1;
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_valid = 1'b0;
            end
        endcase
    end

    assign scan_index = r_idx;
    assign out_valid  = r_valid;
    assign out_id     = r_id;
    assign out_x      = r_x;
    assign out_y      = r_y;
    assign out_index  = r_oidx;
    assign scan_busy  = (r_state != ST_IDLE);
    assign scan_done  = r_done;

endmodule

`default_nettype wire

// File: rtl/entity_table.sv
// entity_table: slot storage for on-screen entities plus a per-frame scan stream to the sprite engine.
// Optional combinational readback port when ENTITY_TABLE_READBACK_EN is defined. Rev 1.0
`default_nettype none

module entity_table
    import entity_pkg::*;
#(
    parameter int NUM_ENTITIES = 16,
    parameter int ID_W         = 4,
    parameter int COORD_W      = 9,
    localparam int AW          = $clog2(NUM_ENTITIES)
) (
    input  logic               CLOCK_50,
    input  logic               RESET_H,
    input  logic               WE,
    input  logic [AW-1:0]      WR_ADDR,
    input  logic [ID_W-1:0]    WR_ID,
    input  logic [COORD_W-1:0] WR_X,
    input  logic [COORD_W-1:0] WR_Y,
    input  logic               WR_VALID,
    input  logic               FRAME_START,
    input  logic               OUT_READY,
    output logic               OUT_VALID,
    output logic [ID_W-1:0]    OUT_ID,
    output logic [COORD_W-1:0] OUT_X,
    output logic [COORD_W-1:0] OUT_Y,
    output logic [AW-1:0]      OUT_INDEX,
    output logic               SCAN_BUSY,
    output logic               SCAN_DONE
`ifdef ENTITY_TABLE_READBACK_EN
    ,
    input  logic [AW-1:0]      RD_ADDR,
    output logic [ID_W-1:0]    RD_ID,
    output logic [COORD_W-1:0] RD_X,
    output logic [COORD_W-1:0] RD_Y,
    output logic               RD_VALID
`endif
);

    // Slot records are packed with the package field widths, so the port widths must agree.
    generate
        if (ID_W != ENT_ID_W || COORD_W != ENT_COORD_W) begin : g_width_check
            $error("entity_table: ID_W/COORD_W must match entity_pkg field widths");
        end
    endgenerate

    localparam entity_t C_PLAYER = {PLAYER_ID, PLAYER_X, PLAYER_Y, 1'b1};

    entity_t       r_slots [NUM_ENTITIES];
    entity_t       w_wr;
    entity_t       w_slot;
    logic [AW-1:0] w_scan_index;

    assign w_wr = {WR_ID, WR_X, WR_Y, WR_VALID};

    always_ff @(posedge CLOCK_50 or posedge RESET_H) begin
        if (RESET_H) begin
            for (int i = 0; i < NUM_ENTITIES; i++) begin
                r_slots[i] <= '0;
            end
            r_slots[0] <= C_PLAYER;
        end else if (WE) begin
            r_slots[WR_ADDR] <= w_wr;
        end
    end

    // Read is from the flops, so a same-edge write to the scanned slot is seen next frame.
    assign w_slot = r_slots[w_scan_index];

    entity_scanner #(
        .NUM_ENTITIES (NUM_ENTITIES)
    ) u_scanner (
        .clk         (CLOCK_50),
        .rst         (RESET_H),
        .frame_start (FRAME_START),
        .out_ready   (OUT_READY),
        .slot        (w_slot),
        .scan_index  (w_scan_index),
        .out_valid   (OUT_VALID),
        .out_id      (OUT_ID),
        .out_x       (OUT_X),
        .out_y       (OUT_Y),
        .out_index   (OUT_INDEX),
        .scan_busy   (SCAN_BUSY),
        .scan_done   (SCAN_DONE)
    );

`ifdef ENTITY_TABLE_READBACK_EN
    assign RD_ID    = r_slots[RD_ADDR].id;
    assign RD_X     = r_slots[RD_ADDR].x;
    assign RD_Y     = r_slots[RD_ADDR].y;
    assign RD_VALID = r_slots[RD_ADDR].valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_entity_table.sv
// tb_entity_table: randomized self-checking bench for entity_table against a slot-array reference model.
// Rev 1.0
`default_nettype none

module tb_entity_table;

    localparam int N = 16;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_H;
    logic       WE;
    logic [3:0] WR_ADDR;
    logic [3:0] WR_ID;
    logic [8:0] WR_X;
    logic [8:0] WR_Y;
    logic       WR_VALID;
    logic       FRAME_START;
    logic       OUT_READY;
    logic       OUT_VALID;
    logic [3:0] OUT_ID;
    logic [8:0] OUT_X;
    logic [8:0] OUT_Y;
    logic [3:0] OUT_INDEX;
    logic       SCAN_BUSY;
    logic       SCAN_DONE;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_id [N];
    logic [8:0] m_x  [N];
    logic [8:0] m_y  [N];
    logic       m_v  [N];

    entity_table dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_H     (RESET_H),
        .WE          (WE),
        .WR_ADDR     (WR_ADDR),
        .WR_ID       (WR_ID),
        .WR_X        (WR_X),
        .WR_Y        (WR_Y),
        .WR_VALID    (WR_VALID),
        .FRAME_START (FRAME_START),
        .OUT_READY   (OUT_READY),
        .OUT_VALID   (OUT_VALID),
        .OUT_ID      (OUT_ID),
        .OUT_X       (OUT_X),
        .OUT_Y       (OUT_Y),
        .OUT_INDEX   (OUT_INDEX),
        .SCAN_BUSY   (SCAN_BUSY),
        .SCAN_DONE   (SCAN_DONE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < N; i++) begin
            m_id[i] = '0; m_x[i] = '0; m_y[i] = '0; m_v[i] = 1'b0;
        end
        m_v[0] = 1'b1; m_x[0] = 9'd32; m_y[0] = 9'd32;
    endtask

    task automatic write_slot(input int a, input int id, input int x, input int y, input bit v);
        WE = 1'b1; WR_ADDR = 4'(a); WR_ID = 4'(id); WR_X = 9'(x); WR_Y = 9'(y); WR_VALID = v;
        step();
        WE = 1'b0;
        m_id[a] = 4'(id); m_x[a] = 9'(x); m_y[a] = 9'(y); m_v[a] = v;
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles on slot 3's beat.
    // wr_cyc >= 0 rewrites slot 9 with X=100 at that cycle; fs_cyc >= 0 pulses FRAME_START mid-scan.
    task automatic run_frame(input int mode, input int wr_cyc, input int fs_cyc, output int beats);
        int         exp_q[$];
        int         s;
        bit         held, done_seen, r;
        int         stall;
        logic [3:0] h_id, h_idx;
        logic [8:0] h_x, h_y;
        beats = 0; held = 0; done_seen = 0; stall = 0;
        h_id = '0; h_idx = '0; h_x = '0; h_y = '0;
        for (int i = 0; i < N; i++) if (m_v[i]) exp_q.push_back(i);
        FRAME_START = 1'b1; OUT_READY = 1'b1;
        step();
        for (int cyc = 0; cyc < 120 && !done_seen; cyc++) begin
            WE = 1'b0; FRAME_START = 1'b0;
            if (cyc == wr_cyc) begin
                WE = 1'b1; WR_ADDR = 4'd9; WR_ID = m_id[9]; WR_X = 9'd100; WR_Y = m_y[9]; WR_VALID = 1'b1;
            end
            if (cyc == fs_cyc) FRAME_START = 1'b1;
            if (held) begin
                n_checks++;
                if (OUT_VALID !== 1'b1 || OUT_ID !== h_id || OUT_X !== h_x || OUT_Y !== h_y || OUT_INDEX !== h_idx) begin
                    n_fail++;
                    $display("FAIL stall_stable cyc=%0d got v=%b idx=%0d id=%0d x=%0d y=%0d want v=1 idx=%0d id=%0d x=%0d y=%0d",
                             cyc, OUT_VALID, OUT_INDEX, OUT_ID, OUT_X, OUT_Y, h_idx, h_id, h_x, h_y);
                end
            end
            if (SCAN_DONE === 1'b1) begin
                done_seen = 1;
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL done_early got %0d beats outstanding want 0", exp_q.size());
                end
                n_checks++;
                if (SCAN_BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_state got busy=%b valid=%b want busy=0 valid=0", SCAN_BUSY, OUT_VALID);
                end
                if (mode == 0) begin
                    n_checks++;
                    if (cyc != N + 1) begin
                        n_fail++;
                        $display("FAIL done_cycle got %0d want %0d", cyc, N + 1);
                    end
                end
            end else begin
                n_checks++;
                if (SCAN_BUSY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy cyc=%0d got %b want 1", cyc, SCAN_BUSY);
                end
            end
            if (mode == 1) r = 1'($urandom_range(0, 1));
            else if (mode == 2 && OUT_VALID === 1'b1 && OUT_INDEX == 4'd3 && stall < 5) begin
                r = 1'b0; stall++;
            end else r = 1'b1;
            OUT_READY = r;
            held = 0;
            if (OUT_VALID === 1'b1) begin
                if (r) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_beat got idx=%0d want no beat", OUT_INDEX);
                    end else begin
                        s = exp_q.pop_front();
                        if (OUT_INDEX !== 4'(s) || OUT_ID !== m_id[s] || OUT_X !== m_x[s] || OUT_Y !== m_y[s]) begin
                            n_fail++;
                            $display("FAIL beat got idx=%0d id=%0d x=%0d y=%0d want idx=%0d id=%0d x=%0d y=%0d",
                                     OUT_INDEX, OUT_ID, OUT_X, OUT_Y, s, m_id[s], m_x[s], m_y[s]);
                        end
                    end
                    beats++;
                    if (mode == 0) begin
                        n_checks++;
                        if (OUT_INDEX !== 4'(cyc - 1)) begin
                            n_fail++;
                            $display("FAIL beat_timing cyc=%0d got idx=%0d want idx=%0d", cyc, OUT_INDEX, cyc - 1);
                        end
                    end
                end else begin
                    held = 1;
                    h_id = OUT_ID; h_x = OUT_X; h_y = OUT_Y; h_idx = OUT_INDEX;
                end
            end
            step();
        end
        WE = 1'b0; FRAME_START = 1'b0; OUT_READY = 1'b1;
        n_checks++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL scan_timeout got no SCAN_DONE want SCAN_DONE");
        end
        if (mode == 2) begin
            n_checks++;
            if (stall != 5) begin
                n_fail++;
                $display("FAIL stall_count got %0d want 5", stall);
            end
        end
        if (wr_cyc >= 0) m_x[9] = 9'd100;
    endtask

    task automatic test_reset;
        int beats;
        RESET_H = 1'b1; WE = 1'b0; WR_ADDR = '0; WR_ID = '0; WR_X = '0; WR_Y = '0;
        WR_VALID = 1'b0; FRAME_START = 1'b0; OUT_READY = 1'b1;
        model_reset();
        step(); step();
        n_checks++;
        if (OUT_VALID !== 1'b0 || OUT_ID !== 4'd0 || OUT_X !== 9'd0 || OUT_Y !== 9'd0 ||
            OUT_INDEX !== 4'd0 || SCAN_BUSY !== 1'b0 || SCAN_DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b id=%0d x=%0d y=%0d idx=%0d busy=%b done=%b want all 0",
                     OUT_VALID, OUT_ID, OUT_X, OUT_Y, OUT_INDEX, SCAN_BUSY, SCAN_DONE);
        end
        #2 RESET_H = 1'b0;
        step();
        run_frame(0, -1, -1, beats);
        n_checks++;
        if (beats != 1) begin
            n_fail++;
            $display("FAIL player_beats got %0d want 1", beats);
        end
    endtask

    task automatic test_all_valid;
        int beats;
        for (int i = 0; i < N; i++) write_slot(i, i, i, 2 * i, 1'b1);
        run_frame(0, -1, -1, beats);
        n_checks++;
        if (beats != N) begin
            n_fail++;
            $display("FAIL all_valid_beats got %0d want %0d", beats, N);
        end
    endtask

    task automatic test_backpressure;
        int beats;
        for (int i = 0; i < N; i++) write_slot(i, 0, 0, 0, 1'b0);
        write_slot(3, $urandom_range(0, 15), $urandom_range(0, 511), $urandom_range(0, 511), 1'b1);
        write_slot(9, $urandom_range(0, 15), $urandom_range(0, 511), $urandom_range(0, 511), 1'b1);
        run_frame(2, -1, -1, beats);
        n_checks++;
        if (beats != 2) begin
            n_fail++;
            $display("FAIL backpressure_beats got %0d want 2", beats);
        end
    endtask

    task automatic test_back_to_back_write;
        int beats;
        for (int i = 0; i < N; i++) write_slot(i, i, i, 2 * i, 1'b1);
        run_frame(0, 9, 4, beats);
        run_frame(0, -1, -1, beats);
        n_checks++;
        if (beats != N) begin
            n_fail++;
            $display("FAIL rbw_next_frame_beats got %0d want %0d", beats, N);
        end
    endtask

    task automatic test_reset_midscan;
        int  beats;
        bit  found;
        found = 0;
        FRAME_START = 1'b1; OUT_READY = 1'b1;
        step();
        FRAME_START = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (OUT_VALID === 1'b1 && OUT_INDEX == 4'd5) found = 1;
            else step();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midscan_reach got no beat idx 5 want beat idx 5");
        end
        RESET_H = 1'b1;
        #1;
        n_checks++;
        if (OUT_VALID !== 1'b0 || SCAN_BUSY !== 1'b0 || SCAN_DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b busy=%b done=%b want 0 0 0", OUT_VALID, SCAN_BUSY, SCAN_DONE);
        end
        step(); step();
        #2 RESET_H = 1'b0;
        model_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            n_checks++;
            if (SCAN_DONE !== 1'b0 || SCAN_BUSY !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle got done=%b busy=%b want 0 0", SCAN_DONE, SCAN_BUSY);
            end
        end
        run_frame(0, -1, -1, beats);
        n_checks++;
        if (beats != 1) begin
            n_fail++;
            $display("FAIL reset_table_beats got %0d want 1", beats);
        end
    endtask

    task automatic test_empty;
        int beats;
        for (int i = 0; i < N; i++) write_slot(i, $urandom_range(0, 15), $urandom_range(0, 511), 0, 1'b0);
        run_frame(0, -1, -1, beats);
        n_checks++;
        if (beats != 0) begin
            n_fail++;
            $display("FAIL empty_beats got %0d want 0", beats);
        end
    endtask

    task automatic test_random;
        int beats, exp_beats;
        for (int it = 0; it < 5; it++) begin
            for (int w = 0; w < 10; w++) begin
                write_slot($urandom_range(0, N - 1), $urandom_range(0, 15), $urandom_range(0, 511),
                           $urandom_range(0, 511), 1'($urandom_range(0, 1)));
            end
            exp_beats = 0;
            for (int i = 0; i < N; i++) if (m_v[i]) exp_beats++;
            run_frame(1, -1, -1, beats);
            n_checks++;
            if (beats != exp_beats) begin
                n_fail++;
                $display("FAIL random_beats iter=%0d got %0d want %0d", it, beats, exp_beats);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_backpressure();
        test_back_to_back_write();
        test_reset_midscan();
        test_empty();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
